ohc_11_forward_converter: RTL and testbench

- Binary-to-residue forward converter for the modulo-11 RNS channel. Converts an unsigned binary operand into the 11-bit one-hot residue code (bit k set means residue k) used by the one-hot modulo-11 arithmetic units.
- Processes the operand MSB-first, BITS_PER_CYC bits per clock, using one-hot doubling (a wire permutation) plus one-hot addition of the incoming bits.
- Sits between the binary datapath and the one-hot modulo-11 adders. It uses a valid/ready handshake on both sides.

---
 rtl/ohc_11_forward_converter.sv | 128 ++++++++++++
 tb/tb_ohc_11_forward_converter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ohc_11_forward_converter.sv
// Binary to one-hot modulo-11 residue converter, MSB-first, BITS_PER_CYC bits per clock.
// Optional one-hot integrity monitor enabled by defining OHC11_ONEHOT_CHECK_EN.
module ohc_11_forward_converter #(
    parameter int DATA_W       = 16,
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_residue,
    output logic              busy,
    output logic              err_onehot
);

    localparam int N     = DATA_W / BITS_PER_CYC;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [10:0]       acc, acc_nxt;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        add;
    logic              last_step;

    // Residue k moves to residue 2k mod 11: pure wiring.
    function automatic logic [10:0] oh_dbl(input logic [10:0] a);
        logic [10:0] r;
        r = '0;
        for (int k = 0; k < 11; k++) r[(2 * k) % 11] = a[k];
        return r;
    endfunction

    function automatic logic [10:0] oh_rot(input logic [10:0] a, input logic [1:0] s);
        logic [10:0] r;
        case (s)
            2'd0:    r = a;
            2'd1:    r = {a[9:0], a[10]};
            2'd2:    r = {a[8:0], a[10:9]};
            default: r = {a[7:0], a[10:8]};
        endcase
        return r;
    endfunction

    always_comb begin
        add     = 2'd0;
        acc_nxt = acc;
        if (BITS_PER_CYC == 2) begin
            add     = sr[DATA_W-1 -: 2];
            acc_nxt = oh_rot(oh_dbl(oh_dbl(acc)), add);
        end else begin
            add     = {1'b0, sr[DATA_W-1]};
            acc_nxt = oh_rot(oh_dbl(acc), add);
        end
    end

    assign last_step = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= 11'b000_0000_0001;
            sr          <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_residue <= 11'b000_0000_0001;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr  <= in_data;
                    acc <= 11'b000_0000_0001;
                    cnt <= CNT_W'(N);
                end
                RUN: begin
                    acc <= acc_nxt;
                    sr  <= sr << BITS_PER_CYC;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        out_valid   <= 1'b1;
                        out_residue <= acc_nxt;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef OHC11_ONEHOT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err_onehot <= 1'b0;
        else if ($countones(acc) != 1)  err_onehot <= 1'b1;
    end
`else
    assign err_onehot = 1'b0;
`endif

endmodule

// File: tb/tb_ohc_11_forward_converter.sv
// Bench for ohc_11_forward_converter: one BITS_PER_CYC=1 and one BITS_PER_CYC=2 instance
// checked every cycle against a value-mod-11 model, plus literal spot checks.
module tb_ohc_11_forward_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [2];
    logic        irdy [2];
    logic        ov   [2];
    logic        ordy [2];
    logic        bsy  [2];
    logic        err  [2];
    logic [15:0] id   [2];
    logic [10:0] ores [2];

    int total  = 0;
    int passed = 0;
    int nstep [2] = '{16, 8};

    always #5 clk = ~clk;

    ohc_11_forward_converter #(.DATA_W(16), .BITS_PER_CYC(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_residue(ores[0]), .busy(bsy[0]),
        .err_onehot(err[0]));

    ohc_11_forward_converter #(.DATA_W(16), .BITS_PER_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_residue(ores[1]), .busy(bsy[1]),
        .err_onehot(err[1]));

    task automatic chk(input string nm, input int inst, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s[%0d]: got %0d (0x%0h) expected %0d (0x%0h)", nm, inst, act, act, exp, exp);
    endtask

    // Model: steps remaining until the result, whether a result is pending, and its residue.
    int m_rem  [2] = '{0, 0};
    bit m_done [2] = '{0, 0};
    int m_res  [2] = '{0, 0};
    int m_val  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_rem[i]  = 0;
                m_done[i] = 0;
            end else if (m_done[i]) begin
                if (ordy[i]) m_done[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_done[i] = 1;
                    m_res[i]  = m_val[i] % 11;
                end
            end else if (iv[i]) begin
                m_rem[i] = nstep[i];
                m_val[i] = int'(id[i]);
            end
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, irdy[i], (!rst && !m_done[i] && m_rem[i] == 0));
            chk("busy", i, bsy[i], (m_done[i] || m_rem[i] > 0));
            chk("out_valid", i, ov[i], m_done[i]);
            if (m_done[i]) chk("out_residue", i, ores[i], 64'd1 << m_res[i]);
            chk("onehot", i, $countones(ores[i]), 1);
            chk("err_onehot", i, err[i], 0);
        end
    end

    // Starts from a negedge in IDLE; returns at a negedge in IDLE after the handshake.
    task automatic run_op(input int s, input logic [15:0] d, input int hold,
                          input bit use_lit, input logic [10:0] lit);
        int lat;
        @(negedge clk);
        iv[s] = 1'b1;
        id[s] = d;
        @(negedge clk);
        id[s] = 16'($urandom);
        lat = 0;
        while (!ov[s] && lat < 200) begin
            iv[s]   = 1'($urandom_range(0, 1));
            ordy[s] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        iv[s]   = 1'b0;
        ordy[s] = 1'b0;
        chk("latency", s, lat, nstep[s]);
        if (use_lit) chk("residue_lit", s, ores[s], lit);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", s, ov[s], 1);
            chk("hold_ready", s, irdy[s], 0);
            if (use_lit) chk("hold_residue", s, ores[s], lit);
        end
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        chk("idle_after_hs", s, irdy[s], 1);
        chk("valid_after_hs", s, ov[s], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_residue", 0, ores[0], 11'b000_0000_0001);
        chk("reset_residue", 1, ores[1], 11'b000_0000_0001);
        chk("reset_ready", 0, irdy[0], 0);
        chk("reset_busy", 0, bsy[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 0, irdy[0], 1);

        run_op(0, 16'd0,    0, 1, 11'b000_0000_0001);
        run_op(0, 16'hFFFF, 0, 1, 11'b001_0000_0000);
        run_op(0, 16'd1234, 5, 1, 11'b000_0000_0100);

        // Back-to-back 10 then 11 with out_ready held high.
        @(negedge clk);
        ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 16'd10;
        @(negedge clk);
        id[0] = 16'd11;
        lat = 0;
        while (!ov[0] && lat < 200) begin @(negedge clk); lat++; end
        chk("b2b_latency_a", 0, lat, 16);
        chk("b2b_residue_a", 0, ores[0], 11'b100_0000_0000);
        @(negedge clk);
        chk("b2b_ready", 0, irdy[0], 1);
        @(negedge clk);
        iv[0] = 1'b0;
        chk("b2b_second_accept", 0, bsy[0], 1);
        lat = 0;
        while (!ov[0] && lat < 200) begin @(negedge clk); lat++; end
        chk("b2b_latency_b", 0, lat, 16);
        chk("b2b_residue_b", 0, ores[0], 11'b000_0000_0001);
        @(negedge clk);
        ordy[0] = 1'b0;

        run_op(1, 16'hABCD, 2, 1, 11'b000_0000_1000);

        // Abort in the 5th RUN cycle.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = 16'h1357;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_run_valid", 0, ov[0], 0);
        chk("abort_run_busy", 0, bsy[0], 0);
        chk("abort_run_ready", 0, irdy[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_run_idle", 0, irdy[0], 1);

        // Abort while a result is pending.
        @(negedge clk);
        iv[1] = 1'b1; id[1] = 16'd77;
        @(negedge clk);
        iv[1] = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 200) begin @(negedge clk); lat++; end
        chk("abort_done_pre", 1, ov[1], 1);
        rst = 1'b1;
        #1;
        chk("abort_done_valid", 1, ov[1], 0);
        chk("abort_done_busy", 1, bsy[1], 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 16'd100, 0, 1, 11'b000_0000_0010);
        run_op(1, 16'd100, 0, 1, 11'b000_0000_0010);

        for (int k = 0; k < 4; k++) begin
            int m;
            m = 11 * $urandom_range(0, 5957);
            run_op(k % 2, 16'(m), 0, 1, 11'b000_0000_0001);
        end
        for (int k = 0; k < 30; k++)
            run_op(k % 3 == 0 ? 1 : 0, 16'($urandom), $urandom_range(0, 3), 0, 11'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
